// File: rtl/mvm_uart_pkg.sv
// mvm_uart_pkg: shared defaults, derived byte counts and state
// encodings for the UART matrix-vector host.
package mvm_uart_pkg;
    localparam int DEF_CLOCKS_PER_PULSE = 33;
    localparam int DEF_BITS_PER_WORD    = 8;
    localparam int DEF_W_Y_OUT          = 8;
    localparam int DEF_R                = 2;
    localparam int DEF_C                = 2;
    localparam int DEF_TIMEOUT_BITS     = 4096;

    function automatic int n_tx(input int r, input int c);
        return r * c + c;
    endfunction

    function automatic int n_rx(input int r, input int w_y,
                                input int bpw);
        return r * w_y / bpw;
    endfunction

    localparam int N_TX = n_tx(DEF_R, DEF_C);
    localparam int N_RX = n_rx(DEF_R, DEF_W_Y_OUT, DEF_BITS_PER_WORD);

    typedef enum logic [1:0] {IDLE, SEND, RECV} host_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
    } rx_state_t;
endpackage

// File: rtl/host_uart_rx.sv
// host_uart_rx: synchronizing UART receiver, one strobe per byte.
// Ports: clk, rstn, rx in; byte_data, byte_valid, frame_err out.
module host_uart_rx
    import mvm_uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] byte_data,
    output logic                     byte_valid,
    output logic                     frame_err
);
    localparam int CW = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int BW = $clog2(BITS_PER_WORD + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_WORD - 1);

    rx_state_t state, state_d;
    logic rx_meta, rx_sync;
    logic [CW-1:0] cnt, cnt_d;
    logic [BW-1:0] bit_idx, bit_d;
    logic [BITS_PER_WORD-1:0] shreg, sh_d;
    logic stop_pt;

    assign stop_pt    = state == RX_STOP && cnt == CNT_LAST;
    assign byte_valid = stop_pt && rx_sync;
    assign frame_err  = stop_pt && !rx_sync;
    assign byte_data  = shreg;

    always_comb begin
        state_d = state;
        cnt_d   = cnt + CW'(1);
        bit_d   = bit_idx;
        sh_d    = shreg;
        unique case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_sync) state_d = RX_START;
            end
            RX_START: begin
                // mid start bit: a high line here was only a glitch
                if (cnt == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_sync, shreg[BITS_PER_WORD-1:1]};
                    bit_d = bit_idx + BW'(1);
                    if (bit_idx == BIT_LAST) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_sync ? RX_IDLE : RX_WAIT;
                end
            end
            RX_WAIT: begin
                cnt_d = '0;
                if (rx_sync) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            shreg   <= sh_d;
        end
    end
endmodule

// File: rtl/mvm_uart_host.sv
// mvm_uart_host: sends K (row-major) then X as UART frames, then
// collects Y. Ports: clk, rstn, start, s_data/s_valid/s_ready, tx,
// rx, y_flat, busy, done, err. Option macro: MVM_HOST_TIMEOUT_EN.
module mvm_uart_host
    import mvm_uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
    parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD,
    parameter int W_Y_OUT          = DEF_W_Y_OUT,
    parameter int R                = DEF_R,
    parameter int C                = DEF_C,
    parameter int TIMEOUT_BITS     = DEF_TIMEOUT_BITS
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [BITS_PER_WORD-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     tx,
    input  logic                     rx,
    output logic [R*W_Y_OUT-1:0]     y_flat,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err
);
    localparam int TX_BYTES = n_tx(R, C);
    localparam int RX_BYTES = n_rx(R, W_Y_OUT, BITS_PER_WORD);
    localparam int CW  = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int BW  = $clog2(BITS_PER_WORD + 2);
    localparam int TXW = $clog2(TX_BYTES + 1);
    localparam int RXW = $clog2(RX_BYTES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0]  BIT_STOP = BW'(BITS_PER_WORD + 1);
    localparam logic [TXW-1:0] TX_LAST  = TXW'(TX_BYTES - 1);
    localparam logic [RXW-1:0] RX_LAST  = RXW'(RX_BYTES - 1);

    host_state_t state, state_d;
    logic ser_busy, ser_end;
    logic [CW-1:0] ser_cnt;
    logic [BW-1:0] ser_bit;
    logic [BITS_PER_WORD+1:0] ser_shift;
    logic [TXW-1:0] tx_cnt;
    logic [RXW-1:0] rx_cnt;
    logic [BITS_PER_WORD-1:0] rx_byte;
    logic rx_valid, rx_ferr, rx_wr, last_wr, timeout;

    host_uart_rx #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD)
    ) u_rx (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .byte_data (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_ferr)
    );

    // the shift register idles all-ones, so its LSB is the line
    assign tx      = ser_shift[0];
    assign s_ready = state == SEND && !ser_busy;
    assign busy    = state != IDLE;
    assign ser_end = ser_busy && ser_cnt == CNT_LAST
                     && ser_bit == BIT_STOP;
    assign rx_wr   = state == RECV && rx_valid;
    assign last_wr = rx_wr && rx_cnt == RX_LAST;
    assign done    = last_wr || timeout;

`ifdef MVM_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_BITS + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_BITS - 1);
    logic [CW-1:0] to_clk;
    logic [TW-1:0] to_bits;

    assign timeout = state == RECV && to_clk == CNT_LAST
                     && to_bits == TO_LAST;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_clk  <= '0;
            to_bits <= '0;
        end else if (state != RECV || rx_wr) begin
            to_clk  <= '0;
            to_bits <= '0;
        end else if (to_clk == CNT_LAST) begin
            to_clk  <= '0;
            to_bits <= to_bits + TW'(1);
        end else begin
            to_clk <= to_clk + CW'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start) state_d = SEND;
            SEND:    if (ser_end && tx_cnt == TX_LAST) state_d = RECV;
            RECV:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ser_busy  <= 1'b0;
            ser_cnt   <= '0;
            ser_bit   <= '0;
            ser_shift <= '1;
        end else if (s_valid && s_ready) begin
            ser_busy  <= 1'b1;
            ser_cnt   <= '0;
            ser_bit   <= '0;
            ser_shift <= {1'b1, s_data, 1'b0};
        end else if (ser_busy) begin
            if (ser_cnt == CNT_LAST) begin
                ser_cnt   <= '0;
                ser_bit   <= ser_bit + BW'(1);
                ser_shift <= {1'b1, ser_shift[BITS_PER_WORD+1:1]};
                if (ser_bit == BIT_STOP) ser_busy <= 1'b0;
            end else begin
                ser_cnt <= ser_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            tx_cnt <= '0;
            rx_cnt <= '0;
            y_flat <= '0;
            err    <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && start) begin
                tx_cnt <= '0;
                rx_cnt <= '0;
                err    <= '0;
            end else begin
                if (ser_end) tx_cnt <= tx_cnt + TXW'(1);
                if (rx_wr) begin
                    rx_cnt <= rx_cnt + RXW'(1);
                    for (int i = 0; i < RX_BYTES; i++)
                        if (rx_cnt == RXW'(i))
                            y_flat[i*BITS_PER_WORD +: BITS_PER_WORD]
                                <= rx_byte;
                end
                if (rx_ferr) err[0] <= 1'b1;
                if (timeout) err[1] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mvm_uart_host.sv
// tb_mvm_uart_host: directed bench for mvm_uart_host.
// Decodes tx frames and plays the system side on rx.
module tb_mvm_uart_host;
    localparam int CPP = 33;
    localparam int FRAME = 10 * CPP + 1;

    typedef logic [7:0] bytes6_t [6];
    typedef struct {
        logic [7:0] data;
        bit         ok;
        int         t0;
    } frame_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        tx;
    logic        rx = 1'b1;
    logic [15:0] y_flat;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_total = 0;
    int done_cyc = 0;
    logic busy_at_done = 1'b0;
    logic busy_after = 1'b0;
    logic prev_done = 1'b0;
    frame_t frames[$];
    int hs_q[$];

    mvm_uart_host #(.TIMEOUT_BITS(64)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .tx     (tx),
        .rx     (rx),
        .y_flat (y_flat),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prev_done) busy_after = busy;
        if (done === 1'b1) begin
            done_total++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
        prev_done = done;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic grab_frame();
        logic [9:0] fr;
        bit ok;
        int t0;
        ok = 1;
        t0 = cyc;
        fr = '1;
        for (int b = 0; b < 10; b++)
            for (int k = 0; k < CPP; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (rstn !== 1'b1) return;
                if (k == 0) fr[b] = tx;
                else if (tx !== fr[b]) ok = 0;
            end
        ok = ok && fr[0] == 1'b0 && fr[9] == 1'b1;
        frames.push_back('{fr[8:1], ok, t0});
    endtask

    initial forever begin
        @(negedge clk);
        if (rstn === 1'b1 && tx === 1'b0) grab_frame();
    end

    function automatic logic [31:0] fdata(input int i);
        if (i < frames.size()) return {24'h0, frames[i].data};
        return 32'hdead;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        s_data = b;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (s_ready !== 1'b1) begin
            check("hs_wait", {31'h0, s_ready}, 1);
            s_valid = 1'b0;
            return;
        end
        hs_q.push_back(cyc);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_tx(input bytes6_t b);
        for (int i = 0; i < 6; i++) push_byte(b[i]);
        repeat (FRAME + 9) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_ok,
                           input int n_stop);
        rx = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPP) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPP) @(negedge clk);
        rx = 1'b1;
        repeat (CPP * (n_stop - 1)) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        bytes6_t v;
        int base, good, bad, t, s;

        repeat (3) @(negedge clk);
        check("rst_tx", {31'h0, tx}, 1);
        check("rst_s_ready", {31'h0, s_ready}, 0);
        check("rst_y", {16'h0, y_flat}, 0);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_err", {30'h0, err}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // transmit timing and result capture
        frames.delete();
        hs_q.delete();
        pulse_start();
        check("t1_busy", {31'h0, busy}, 1);
        check("t1_s_ready", {31'h0, s_ready}, 1);
        v = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_tx(v);
        check("t1_nframes", frames.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t1_byte%0d", i), fdata(i), v[i]);
        good = 0;
        for (int i = 0; i < frames.size(); i++)
            if (frames[i].ok) good++;
        check("t1_format", good, 6);
        if (frames.size() > 0 && hs_q.size() > 0)
            check("t1_latency", frames[0].t0 - hs_q[0], 1);
        good = 0;
        for (int i = 1; i < frames.size(); i++)
            if (frames[i].t0 - frames[i-1].t0 == FRAME) good++;
        check("t1_spacing", good, 5);
        check("t1_recv_ready", {31'h0, s_ready}, 0);
        check("t1_recv_busy", {31'h0, busy}, 1);
        base = done_total;
        send_rx(8'h11, 1, 4);
        send_rx(8'h27, 1, 4);
        repeat (5) @(negedge clk);
        check("t1_done_cnt", done_total - base, 1);
        check("t1_busy_at_done", {31'h0, busy_at_done}, 1);
        check("t1_busy_after", {31'h0, busy_after}, 0);
        check("t1_y", {16'h0, y_flat}, 32'h2711);
        check("t1_err", {30'h0, err}, 0);

        // framing error on the first returned byte
        pulse_start();
        v = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        send_tx(v);
        base = done_total;
        send_rx(8'h5A, 0, 4);
        send_rx(8'h33, 1, 4);
        send_rx(8'h44, 1, 4);
        repeat (5) @(negedge clk);
        check("t2_err", {30'h0, err}, 2'b01);
        check("t2_y", {16'h0, y_flat}, 32'h4433);
        check("t2_done_cnt", done_total - base, 1);

        // gapped s_valid and a start pulse mid-SEND
        frames.delete();
        hs_q.delete();
        pulse_start();
        check("t3_err_clr", {30'h0, err}, 0);
        v = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            push_byte(v[i]);
            repeat (FRAME + 4) @(negedge clk);
            for (int g = 0; g < 40; g++) begin
                start = (i == 1 && g == 10);
                @(negedge clk);
                if (tx !== 1'b1) bad++;
            end
            start = 1'b0;
        end
        check("t3_gap_idle", bad, 0);
        check("t3_nframes", frames.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t3_byte%0d", i), fdata(i), v[i]);
        check("t3_recv_ready", {31'h0, s_ready}, 0);
        base = done_total;
        send_rx(8'h01, 1, 4);
        send_rx(8'h80, 1, 4);
        repeat (5) @(negedge clk);
        check("t3_y", {16'h0, y_flat}, 32'h8001);
        check("t3_done_cnt", done_total - base, 1);

        // reset in the middle of data bit 3
        hs_q.delete();
        pulse_start();
        push_byte(8'hC3);
        repeat (CPP * 4 + 15) @(negedge clk);
        check("t4_bit3", {31'h0, tx}, 0);
        rstn = 1'b0;
        #1;
        check("t4_tx", {31'h0, tx}, 1);
        check("t4_s_ready", {31'h0, s_ready}, 0);
        check("t4_y", {16'h0, y_flat}, 0);
        check("t4_busy", {31'h0, busy}, 0);
        check("t4_done", {31'h0, done}, 0);
        check("t4_err", {30'h0, err}, 0);
        repeat (4) @(negedge clk);
        check("t4_tx_hold", {31'h0, tx}, 1);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        frames.delete();
        pulse_start();
        v = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        send_tx(v);
        check("t4_nframes", frames.size(), 6);
        check("t4_first", fdata(0), 8'h21);
        check("t4_last", fdata(5), 8'h26);
        base = done_total;
        send_rx(8'hBE, 1, 4);
        send_rx(8'hEF, 1, 4);
        repeat (5) @(negedge clk);
        check("t4_y_fresh", {16'h0, y_flat}, 32'hEFBE);
        check("t4_err_fresh", {30'h0, err}, 0);
        check("t4_done_cnt", done_total - base, 1);

        // one returned byte, then silence
        pulse_start();
        v = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
        send_tx(v);
        base = done_total;
        s = cyc;
        send_rx(8'h77, 1, 4);
`ifdef MVM_HOST_TIMEOUT_EN
        t = 0;
        while (done_total == base && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("t5_done_cnt", done_total - base, 1);
        good = (done_cyc - s >= 2412 && done_cyc - s <= 2442);
        check("t5_delay", good, 1);
        repeat (2) @(negedge clk);
        check("t5_err", {30'h0, err}, 2'b10);
        check("t5_y_lo", {24'h0, y_flat[7:0]}, 8'h77);
        check("t5_y_hi", {24'h0, y_flat[15:8]}, 8'hEF);
        check("t5_busy", {31'h0, busy}, 0);
`else
        t = s;
        repeat (3000) @(negedge clk);
        check("t5_no_done", done_total - base, 0);
        check("t5_wait_busy", {31'h0, busy}, 1);
        send_rx(8'h99, 1, 4);
        repeat (5) @(negedge clk);
        check("t5_done_cnt", done_total - base, 1);
        check("t5_y", {16'h0, y_flat}, 32'h9977);
        check("t5_err", {30'h0, err}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
